// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage assembling one/two-byte instructions for the decoder
module instruction_fetch #(
    parameter int LONG_BIT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_in,
    output logic       pc_enable,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    input  logic       stall,
    input  logic       flush,
    input  logic       instr_ready,
    output logic       instr_valid,
    output logic [7:0] opcode,
    output logic [7:0] operand
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        WAIT_OP,
        FETCH_ARG,
        WAIT_ARG,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;
    logic   capture_op;
    logic   capture_arg;
    logic   clear_arg;

    // State register; reset drops any partially assembled instruction at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction byte latches, written only in the cycle memory data returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode  <= 8'h00;
            operand <= 8'h00;
        end else begin
            if (capture_op) begin
                opcode <= mem_data;
            end
            if (capture_arg) begin
                operand <= mem_data;
            end else if (clear_arg) begin
                operand <= 8'h00;
            end
        end
    end

    // Next-state and strobes; flush wins over stall so the PC load never meets an increment
    always_comb begin
        state_next  = state;
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        capture_op  = 1'b0;
        capture_arg = 1'b0;
        clear_arg   = 1'b0;
        if (flush && state != IDLE) begin
            state_next = FETCH_OP;
        end else begin
            case (state)
                IDLE: begin
                    state_next = FETCH_OP;
                end
                FETCH_OP: begin
                    if (!stall) begin
                        mem_rd     = 1'b1;
                        state_next = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    capture_op = 1'b1;
                    if (mem_data[LONG_BIT]) begin
                        state_next = FETCH_ARG;
                    end else begin
                        clear_arg  = 1'b1;
                        state_next = HOLD;
                    end
                end
                FETCH_ARG: begin
                    if (!stall) begin
                        mem_rd     = 1'b1;
                        state_next = WAIT_ARG;
                    end
                end
                WAIT_ARG: begin
                    capture_arg = 1'b1;
                    state_next  = HOLD;
                end
                HOLD: begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        state_next = FETCH_OP;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // One increment per byte read; address is driven only while reading
    assign pc_enable = mem_rd;
    assign mem_addr  = mem_rd ? pc_in : 8'h00;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc = 8'h00;
    logic       pc_enable;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data = 8'h00;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       instr_ready = 1'b1;
    logic       instr_valid;
    logic [7:0] opcode;
    logic [7:0] operand;

    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'h00;
    logic [7:0] mem [256];

    int vectors = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  ref_pc = 8'h00;

    instruction_fetch dut (
        .clk(clk),
        .reset(reset),
        .pc_in(pc),
        .pc_enable(pc_enable),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .stall(stall),
        .flush(flush),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .opcode(opcode),
        .operand(operand)
    );

    always #5 clk = ~clk;

    // Environment: program counter with load priority over increment
    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= 8'h00;
        else if (ld) pc <= ld_val;
        else if (pc_enable) pc <= pc + 8'd1;
    end

    // Environment: synchronous program memory
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the instruction at ref_pc is mem[ref_pc], plus mem[ref_pc+1] if bit 7 is set
    task automatic push_next();
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] nxt;
        op  = mem[ref_pc];
        nxt = ref_pc + 8'd1;
        arg = 8'h00;
        if (op[7]) begin
            arg = mem[nxt];
            nxt = nxt + 8'd1;
        end
        exp_q.push_back({op, arg});
        ref_pc = nxt;
    endtask

    task automatic restart(input logic [7:0] target);
        exp_q.delete();
        ref_pc = target;
        push_next();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
            else next_cycle();
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor: protocol invariants plus scoreboard comparison on every handshake
    logic       prev_pce = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_op = 8'h00;
    logic [7:0] prev_arg = 8'h00;
    always @(negedge clk) begin
        logic [15:0] exp;
        if (!reset) begin
            prev_pce  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("pce_eq_rd", 32'(pc_enable), 32'(mem_rd));
            if (mem_rd) check("addr_eq_pc", 32'(mem_addr), 32'(pc));
            check("pce_pulse", 32'(prev_pce & pc_enable), 32'd0);
            if (flush) check("flush_quiet", 32'({pc_enable, mem_rd, instr_valid}), 32'd0);
            if (stall) check("stall_no_rd", 32'(mem_rd), 32'd0);
            if (prev_hold && !flush)
                check("hold_stable", 32'({instr_valid, opcode, operand}), 32'({1'b1, prev_op, prev_arg}));
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", 32'({opcode, operand}), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("instr", 32'({opcode, operand}), 32'(exp));
                    push_next();
                end
            end
            prev_pce  = pc_enable;
            prev_hold = instr_valid && !instr_ready;
            prev_op   = opcode;
            prev_arg  = operand;
        end
    end

    initial begin
        logic [9:0] rd_pat;
        logic [9:0] valid_pat;
        logic [7:0] addr_tab [10];
        int         pce_a;
        int         pce_b;
        logic [7:0] tgt;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h05; mem[8'h01] = 8'h8A; mem[8'h02] = 8'h3C; mem[8'h03] = 8'h11;
        mem[8'h04] = 8'h9B; mem[8'h05] = 8'h44; mem[8'h06] = 8'hC1; mem[8'h07] = 8'h55;
        mem[8'h18] = 8'h07; mem[8'hFF] = 8'h81;

        // Reset held two cycles
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_outputs", 32'({pc_enable, mem_rd, instr_valid, opcode, operand, mem_addr}), 32'd0);

        // Release: one-byte then two-byte instruction, cycle-exact
        next_cycle();
        reset = 1'b1;
        restart(8'h00);
        rd_pat    = 10'b0010100100;
        valid_pat = 10'b1000010000;
        for (int i = 0; i < 10; i++) addr_tab[i] = 8'h00;
        addr_tab[5] = 8'h01;
        addr_tab[7] = 8'h02;
        pce_a = 0;
        pce_b = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("seq_rd_c%0d", i), 32'(mem_rd), 32'(rd_pat[i]));
            check($sformatf("seq_valid_c%0d", i), 32'(instr_valid), 32'(valid_pat[i]));
            if (rd_pat[i]) check($sformatf("seq_addr_c%0d", i), 32'(mem_addr), 32'(addr_tab[i]));
            if (i <= 4) pce_a += int'(pc_enable);
            else pce_b += int'(pc_enable);
            if (i == 4) check("one_byte_instr", 32'({opcode, operand}), 32'h0500);
            if (i == 9) check("two_byte_instr", 32'({opcode, operand}), 32'h8A3C);
            next_cycle();
        end
        check("pce_count_one", 32'(pce_a), 32'd1);
        check("pce_count_two", 32'(pce_b), 32'd2);

        // Backpressure on the instruction at 03
        instr_ready = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("bp_hold", 32'({instr_valid, opcode, operand, mem_rd, pc_enable}), 32'({1'b1, 16'h1100, 2'b00}));
        end
        next_cycle();
        instr_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("bp_release_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h04}));

        // Stall three cycles in FETCH_ARG of 9B 44
        next_cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check("stall_quiet", 32'({mem_rd, pc_enable}), 32'd0);
        end
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h05}));
        wait_valid("stall");
        check("stall_instr", 32'({opcode, operand}), 32'h9B44);
        check("stall_pc", 32'(pc), 32'h06);

        // Flush in WAIT_ARG of C1 55, PC loads 18
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("flush_pre_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h07}));
        next_cycle();
        flush = 1'b1; ld = 1'b1; ld_val = 8'h18;
        restart(8'h18);
        @(negedge clk);
        check("flush_cycle", 32'({pc_enable, mem_rd, instr_valid}), 32'd0);
        next_cycle();
        flush = 1'b0; ld = 1'b0;
        @(negedge clk);
        check("flush_refetch", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'h18}));
        wait_valid("flush");
        check("flush_instr", 32'({opcode, operand}), 32'h0700);

        // Wrap: two-byte instruction straddling FF -> 00
        mem[8'h00] = 8'h22;
        next_cycle();
        flush = 1'b1; ld = 1'b1; ld_val = 8'hFF;
        restart(8'hFF);
        next_cycle();
        flush = 1'b0; ld = 1'b0;
        @(negedge clk);
        check("wrap_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'hFF}));
        wait_valid("wrap");
        check("wrap_instr", 32'({opcode, operand}), 32'h8122);

        // Asynchronous reset mid-WAIT_OP
        next_cycle();
        @(negedge clk);
        check("ar_fetch", 32'(mem_rd), 32'd1);
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        check("ar_outputs", 32'({pc_enable, mem_rd, instr_valid, opcode, operand, mem_addr}), 32'd0);
        next_cycle();
        reset = 1'b1;
        restart(8'h00);
        wait_valid("ar_restart");

        // Randomized traffic with branches, stalls and backpressure
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        next_cycle();
        reset = 1'b1;
        restart(8'h00);
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            instr_ready = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 31) == 0);
            ld          = flush;
            if (flush) begin
                tgt    = 8'($urandom);
                ld_val = tgt;
                restart(tgt);
            end
        end
        next_cycle();
        flush = 1'b0; ld = 1'b0; stall = 1'b0; instr_ready = 1'b1;
        wait_valid("final");
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
